// File: rtl/phy_tx_serializer_if.sv
// Byte handshake between the upstream framer (master) and the serializer (slave).
interface phy_tx_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/phy_tx_serializer.sv
// Byte-to-bit serializer feeding the PHY: MSB-first, training COM burst after reset,
// COM filler whenever no byte is offered at a byte boundary.
module phy_tx_serializer #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned TRAIN_COMS = 4
) (
    input  logic               clk32f,
    input  logic               reset,
    phy_tx_serializer_if.slave up,
    output logic               out,
    output logic               is_com,
    output logic [15:0]        tx_count
);
    typedef enum logic {TRAIN, DATA} state_t;

    localparam logic [3:0] LAST_TRAIN = 4'(TRAIN_COMS - 1);

    state_t      state_q,    state_d;
    logic [7:0]  sr_q,       sr_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [3:0]  com_cnt_q,  com_cnt_d;
    logic        out_q,      out_d;
    logic        is_com_q,   is_com_d;
    logic [15:0] tx_count_q, tx_count_d;

    logic       load;
    logic       ready;
    logic       transfer;
    logic [7:0] load_byte;

    // A byte boundary is the cycle after the last bit of the previous byte went out.
    assign load      = (bit_cnt_q == 3'd7);
    assign ready     = reset && (state_q == DATA) && load;
    assign transfer  = ready && up.in_valid;
    assign load_byte = transfer ? up.in_data : COM_SYMBOL;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        com_cnt_d  = com_cnt_q;
        out_d      = out_q;
        is_com_d   = is_com_q;
        tx_count_d = tx_count_q;

        if (load) begin
            out_d     = load_byte[7];
            sr_d      = {load_byte[6:0], 1'b0};
            bit_cnt_d = 3'd0;
            if (state_q == TRAIN) begin
                is_com_d  = 1'b1;
                com_cnt_d = com_cnt_q + 4'd1;
                if (com_cnt_q == LAST_TRAIN) begin
                    state_d = DATA;
                end
            end else begin
                is_com_d = !transfer;
                if (transfer) begin
                    tx_count_d = tx_count_q + 16'd1;
                end
            end
        end else begin
            out_d     = sr_q[7];
            sr_d      = {sr_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    // bit_cnt resets to 7 so the first edge after release is a load.
    always_ff @(posedge clk32f) begin
        if (!reset) begin
            state_q    <= TRAIN;
            sr_q       <= 8'd0;
            bit_cnt_q  <= 3'd7;
            com_cnt_q  <= 4'd0;
            out_q      <= 1'b0;
            is_com_q   <= 1'b0;
            tx_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            out_q      <= out_d;
            is_com_q   <= is_com_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign up.in_ready = ready;
    assign out         = out_q;
    assign is_com      = is_com_q;
    assign tx_count    = tx_count_q;
endmodule
